// File: rtl/ss_wb_arb.sv
// Two-master Wishbone arbiter: round-robin grant per bus cycle, burst-cap pre-emption via rty.
// Optional bus watchdog is built when ARB_WDOG_EN is defined.
module ss_wb_arb #(
   parameter int MAX_BURST = 16,
   parameter int WDOG_CYC  = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic        m0_cab,
   input  logic [3:0]  m0_sel,
   input  logic [31:0] m0_adr,
   input  logic [63:0] m0_dat_i,
   output logic [63:0] m0_dat_o,
   output logic        m0_ack,
   output logic        m0_rty,
   output logic        m0_err,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic        m1_cab,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m1_adr,
   input  logic [63:0] m1_dat_i,
   output logic [63:0] m1_dat_o,
   output logic        m1_ack,
   output logic        m1_rty,
   output logic        m1_err,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic        s_cab,
   output logic [3:0]  s_sel,
   output logic [31:0] s_adr,
   output logic [63:0] s_dat_i,
   input  logic [63:0] s_dat_o,
   input  logic        s_ack,
   input  logic        s_rty,
   input  logic        s_err,
   output logic [1:0]  gnt,
   output logic        wdog_trip
);

   typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
   localparam bit         PREEMPT_EN  = (MAX_BURST != 0);

   state_t      state_reg, state_next;
   logic        rr_reg, rr_next;
   logic [7:0]  burst_cnt_reg;

   logic        granted;
   logic        mux_cyc, mux_stb, mux_we, mux_cab;
   logic [3:0]  mux_sel;
   logic [31:0] mux_adr;
   logic [63:0] mux_dat;
   logic        other_cyc;
   logic        preempt;
   logic        stb_req;
   logic        wdog_block;
   logic        wdog_fire;
   logic        fwd_ack, fwd_rty, fwd_err;

   // Parameter range guard; an out-of-range setting elaborates this empty block only.
   if (MAX_BURST < 0 || MAX_BURST > 255 || WDOG_CYC < 1 || WDOG_CYC > 65536) begin : g_param_range
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_reg <= IDLE;
         rr_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         rr_reg    <= rr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rr_next    = rr_reg;
      case (state_reg)
         IDLE: begin
            if (m0_cyc && m1_cyc)
               state_next = rr_reg ? G1 : G0;
            else if (m0_cyc)
               state_next = G0;
            else if (m1_cyc)
               state_next = G1;
         end
         G0: begin
            if (!m0_cyc) begin
               state_next = IDLE;
               rr_next    = 1'b1;
            end
         end
         G1: begin
            if (!m1_cyc) begin
               state_next = IDLE;
               rr_next    = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mux_cyc   = 1'b0;
      mux_stb   = 1'b0;
      mux_we    = 1'b0;
      mux_cab   = 1'b0;
      mux_sel   = 4'd0;
      mux_adr   = 32'd0;
      mux_dat   = 64'd0;
      other_cyc = 1'b0;
      case (state_reg)
         G0: begin
            mux_cyc   = m0_cyc;
            mux_stb   = m0_stb;
            mux_we    = m0_we;
            mux_cab   = m0_cab;
            mux_sel   = m0_sel;
            mux_adr   = m0_adr;
            mux_dat   = m0_dat_i;
            other_cyc = m1_cyc;
         end
         G1: begin
            mux_cyc   = m1_cyc;
            mux_stb   = m1_stb;
            mux_we    = m1_we;
            mux_cab   = m1_cab;
            mux_sel   = m1_sel;
            mux_adr   = m1_adr;
            mux_dat   = m1_dat_i;
            other_cyc = m0_cyc;
         end
         default: ;
      endcase
   end

   assign granted = (state_reg != IDLE);

   // Acks in the current tenure; IDLE separates every tenure, so clearing there clears on grant.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n)
         burst_cnt_reg <= 8'd0;
      else if (!granted)
         burst_cnt_reg <= 8'd0;
      else if (s_ack && burst_cnt_reg != 8'hFF)
         burst_cnt_reg <= burst_cnt_reg + 8'd1;
   end

   assign preempt = PREEMPT_EN && granted && other_cyc && (burst_cnt_reg >= MAX_BURST_C);
   assign stb_req = mux_stb & ~preempt;

`ifdef ARB_WDOG_EN
   localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC - 1);

   logic [15:0] wdog_cnt_reg;
   logic        wdog_kill_reg;
   logic        wdog_trip_reg;

   assign wdog_fire  = granted && stb_req && !wdog_kill_reg && (wdog_cnt_reg == WDOG_LIM);
   assign wdog_block = wdog_kill_reg | wdog_fire;

   // Once tripped, the slave stays detached until the master ends its cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wdog_cnt_reg  <= 16'd0;
         wdog_kill_reg <= 1'b0;
         wdog_trip_reg <= 1'b0;
      end else begin
         if (!granted || s_ack || s_rty || s_err)
            wdog_cnt_reg <= 16'd0;
         else if (s_stb)
            wdog_cnt_reg <= wdog_cnt_reg + 16'd1;

         if (!granted)
            wdog_kill_reg <= 1'b0;
         else if (wdog_fire)
            wdog_kill_reg <= 1'b1;

         if (wdog_fire)
            wdog_trip_reg <= 1'b1;
      end
   end

   assign wdog_trip = wdog_trip_reg;
`else
   assign wdog_fire  = 1'b0;
   assign wdog_block = 1'b0;
   assign wdog_trip  = 1'b0;
`endif

   assign s_cyc   = mux_cyc & ~wdog_block;
   assign s_stb   = stb_req & ~wdog_block;
   assign s_we    = mux_we;
   assign s_cab   = mux_cab;
   assign s_sel   = mux_sel;
   assign s_adr   = mux_adr;
   assign s_dat_i = mux_dat;

   assign fwd_ack = s_ack & ~preempt;
   assign fwd_rty = s_rty | preempt;
   assign fwd_err = s_err | wdog_fire;

   assign m0_ack   = (state_reg == G0) & fwd_ack;
   assign m0_rty   = (state_reg == G0) & fwd_rty;
   assign m0_err   = (state_reg == G0) & fwd_err;
   assign m1_ack   = (state_reg == G1) & fwd_ack;
   assign m1_rty   = (state_reg == G1) & fwd_rty;
   assign m1_err   = (state_reg == G1) & fwd_err;
   assign m0_dat_o = granted ? s_dat_o : 64'd0;
   assign m1_dat_o = granted ? s_dat_o : 64'd0;

   assign gnt = {state_reg == G1, state_reg == G0};

endmodule

// File: tb/tb_ss_wb_arb.sv
// Bench for ss_wb_arb: a per-cycle bus-ownership model checks every output on each falling edge;
// directed scenarios add hand-computed literal checks. Watchdog scenario follows ARB_WDOG_EN.
module tb_ss_wb_arb;

   localparam int MAXB = 16;
   localparam int WDOG = 8;
`ifdef ARB_WDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n = 1'b0;
   logic        m0_cyc, m0_stb, m0_we, m0_cab;
   logic [3:0]  m0_sel;
   logic [31:0] m0_adr;
   logic [63:0] m0_dat_i, m0_dat_o;
   logic        m0_ack, m0_rty, m0_err;
   logic        m1_cyc, m1_stb, m1_we, m1_cab;
   logic [3:0]  m1_sel;
   logic [31:0] m1_adr;
   logic [63:0] m1_dat_i, m1_dat_o;
   logic        m1_ack, m1_rty, m1_err;
   logic        s_cyc, s_stb, s_we, s_cab;
   logic [3:0]  s_sel;
   logic [31:0] s_adr;
   logic [63:0] s_dat_i, s_dat_o;
   logic        s_ack, s_rty, s_err;
   logic [1:0]  gnt;
   logic        wdog_trip;

   logic        ack_en = 1'b0;
   logic        err_en = 1'b0;

   int checks = 0;
   int errors = 0;

   // Slave: answers every strobe with ack (or err) when enabled, never retries.
   assign s_ack = ack_en & s_stb;
   assign s_err = err_en & s_stb;
   assign s_rty = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   ss_wb_arb #(.MAX_BURST(MAXB), .WDOG_CYC(WDOG)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cab(m0_cab), .m0_sel(m0_sel),
      .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
      .m0_ack(m0_ack), .m0_rty(m0_rty), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cab(m1_cab), .m1_sel(m1_sel),
      .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
      .m1_ack(m1_ack), .m1_rty(m1_rty), .m1_err(m1_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cab(s_cab), .s_sel(s_sel),
      .s_adr(s_adr), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
      .s_ack(s_ack), .s_rty(s_rty), .s_err(s_err),
      .gnt(gnt), .wdog_trip(wdog_trip)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- ownership model ----------------
   int owner = -1;    // -1 none, else master index holding the bus
   int prio  = 0;     // master that wins a simultaneous request
   int beats = 0;     // acks delivered in this tenure (saturating 255)
   int wd    = 0;     // stalled strobe cycles
   bit kill  = 1'b0;
   bit trip  = 1'b0;
   int ack_n [2];
   int rty_n [2];
   int err_n [2];

   bit          mc [2];
   bit          ms [2];
   bit          mw [2];
   logic [31:0] ma [2];
   bit          e_scyc, e_sstb, e_swe, pre, fire, r_ack, r_err;
   logic [31:0] e_adr;
   logic [63:0] e_dat;
   logic [1:0]  e_gnt, e_ack, e_rty, e_err;
   int          o, oth;

   always @(negedge wb_clk_i) begin
      if (!wb_rst_n) begin
         owner = -1; prio = 0; beats = 0; wd = 0; kill = 1'b0; trip = 1'b0;
      end
      mc[0] = m0_cyc; ms[0] = m0_stb; mw[0] = m0_we; ma[0] = m0_adr;
      mc[1] = m1_cyc; ms[1] = m1_stb; mw[1] = m1_we; ma[1] = m1_adr;
      e_scyc = 0; e_sstb = 0; e_swe = 0; pre = 0; fire = 0; r_ack = 0; r_err = 0;
      e_adr = '0; e_dat = '0; e_gnt = '0; e_ack = '0; e_rty = '0; e_err = '0;
      o = 0; oth = 1;
      if (owner >= 0) begin
         o    = owner;
         oth  = 1 - owner;
         pre  = (MAXB != 0) && (beats >= MAXB) && mc[oth];
         fire = WD_ON && !kill && ms[o] && !pre && (wd == WDOG - 1);
         e_scyc = mc[o] && !kill && !fire;
         e_sstb = ms[o] && !pre && !kill && !fire;
         e_swe  = mw[o];
         e_adr  = ma[o];
         e_dat  = s_dat_o;
         e_gnt[o] = 1'b1;
         r_ack  = ack_en && e_sstb;
         r_err  = err_en && e_sstb;
         e_ack[o] = r_ack && !pre;
         e_rty[o] = pre;
         e_err[o] = r_err || fire;
      end
      chk("gnt", gnt, e_gnt);
      chk("s_cyc", s_cyc, e_scyc);
      chk("s_stb", s_stb, e_sstb);
      chk("s_we", s_we, e_swe);
      chk("s_adr", s_adr, e_adr);
      chk("m0_dat_o", m0_dat_o, e_dat);
      chk("m1_dat_o", m1_dat_o, e_dat);
      chk("ack", {m1_ack, m0_ack}, e_ack);
      chk("rty", {m1_rty, m0_rty}, e_rty);
      chk("err", {m1_err, m0_err}, e_err);
      chk("wdog_trip", wdog_trip, trip);
      ack_n[0] += int'(m0_ack); ack_n[1] += int'(m1_ack);
      rty_n[0] += int'(m0_rty); rty_n[1] += int'(m1_rty);
      err_n[0] += int'(m0_err); err_n[1] += int'(m1_err);
      if (wb_rst_n) begin
         if (owner < 0) begin
            beats = 0; wd = 0; kill = 1'b0;
            if (mc[0] && mc[1]) owner = prio;
            else if (mc[0])     owner = 0;
            else if (mc[1])     owner = 1;
         end else if (!mc[o]) begin
            owner = -1;
            prio  = oth;
         end else begin
            if (r_ack && beats < 255) beats++;
            if (r_ack || r_err)       wd = 0;
            else if (e_sstb)          wd++;
            if (fire) begin kill = 1'b1; trip = 1'b1; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 2; i++) begin ack_n[i] = 0; rty_n[i] = 0; err_n[i] = 0; end
   endtask

   task automatic idle_masters();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_cab = 0; m0_sel = 4'hF; m0_adr = '0; m0_dat_i = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_cab = 0; m1_sel = 4'hF; m1_adr = '0; m1_dat_i = '0;
   endtask

   task automatic do_reset(input string tag);
      wb_rst_n = 1'b0;
      tick();
      tick();
      chk({tag, "_rst_gnt"}, gnt, 2'b00);
      chk({tag, "_rst_scyc"}, s_cyc, 1'b0);
      chk({tag, "_rst_trip"}, wdog_trip, 1'b0);
      wb_rst_n = 1'b1;
      tick();
      clr_counts();
   endtask

   initial begin
      int n;
      bit found;
      idle_masters();
      s_dat_o = 64'h1111_2222_3333_4444;
      clr_counts();

      // 1: m0 alone, 4-beat read
      do_reset("t1");
      ack_en = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1000;
      chk("t1_gnt_latency", gnt, 2'b00);
      tick();
      chk("t1_gnt", gnt, 2'b01);
      chk("t1_s_adr", s_adr, 32'h0000_1000);
      repeat (3) tick();
      tick();
      m0_cyc = 0; m0_stb = 0;
      chk("t1_m0_acks", ack_n[0], 4);
      chk("t1_m1_resp", ack_n[1] + rty_n[1] + err_n[1], 0);
      tick(); tick();

      // 2: simultaneous requests after reset, m0 first, one idle cycle, then m1
      do_reset("t2");
      s_dat_o = 64'hA5A5_0000_5A5A_FFFF;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2000; m1_dat_i = 64'hCAFE;
      tick();
      chk("t2_first_gnt", gnt, 2'b01);
      tick(); tick();
      m0_cyc = 0; m0_stb = 0;
      chk("t2_m0_acks", ack_n[0], 2);
      tick();
      chk("t2_idle_gap", gnt, 2'b00);
      tick();
      chk("t2_second_gnt", gnt, 2'b10);
      chk("t2_s_we", s_we, 1'b1);
      chk("t2_s_dat_i", s_dat_i, 64'hCAFE);
      tick();
      m1_cyc = 0; m1_stb = 0; m1_we = 0;
      tick(); tick();

      // 3: m1 burst pre-empted after 16 acks once m0 waits
      do_reset("t3");
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_3000;
      tick();
      repeat (4) tick();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_4000;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (m1_rty) found = 1;
      end
      chk("t3_rty_seen", found, 1'b1);
      chk("t3_stb_blocked", s_stb, 1'b0);
      chk("t3_m1_acks", ack_n[1], 16);
      tick();
      m1_cyc = 0; m1_stb = 0;
      tick();
      chk("t3_idle", gnt, 2'b00);
      tick();
      chk("t3_m0_gnt", gnt, 2'b01);
      chk("t3_m1_acks_final", ack_n[1], 16);
      tick();
      m0_cyc = 0; m0_stb = 0;
      tick(); tick();

      // 4: m1 alone 40 beats, never pre-empted
      do_reset("t4");
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_5000;
      tick();
      repeat (39) tick();
      tick();
      m1_cyc = 0; m1_stb = 0;
      chk("t4_m1_acks", ack_n[1], 40);
      chk("t4_m1_rty", rty_n[1], 0);
      tick(); tick();

      // 5: slave error on beat 2 of m1
      do_reset("t5");
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_6000;
      tick();
      tick();
      ack_en = 0; err_en = 1;
      tick();
      err_en = 0; ack_en = 1; m1_stb = 0;
      tick();
      chk("t5_gnt_held", gnt, 2'b10);
      tick();
      m1_cyc = 0; m1_we = 0;
      chk("t5_m1_err", err_n[1], 1);
      chk("t5_m0_err", err_n[0], 0);
      chk("t5_m1_acks", ack_n[1], 1);
      tick(); tick();

      // asynchronous reset mid-transfer
      do_reset("tr");
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_7000;
      tick(); tick();
      #2 wb_rst_n = 1'b0;
      #1;
      chk("tr_async_scyc", s_cyc, 1'b0);
      chk("tr_async_sstb", s_stb, 1'b0);
      chk("tr_async_gnt", gnt, 2'b00);
      tick();
      m0_cyc = 0; m0_stb = 0;
      wb_rst_n = 1'b1;
      tick(); tick();

      // 6: silent slave
      do_reset("t6");
      ack_en = 0;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_8000;
`ifdef ARB_WDOG_EN
      n = 0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         n++;
         if (m0_err) found = 1;
      end
      chk("t6_err_seen", found, 1'b1);
      chk("t6_err_cycle", n, WDOG);
      chk("t6_scyc_forced", s_cyc, 1'b0);
      chk("t6_trip", wdog_trip, 1'b1);
      tick();
      chk("t6_err_one_cycle", m0_err, 1'b0);
      m0_cyc = 0; m0_stb = 0;
      tick(); tick();
      chk("t6_trip_sticky", wdog_trip, 1'b1);
      ack_en = 1;
      do_reset("t6b");
`else
      repeat (20) tick();
      chk("t6_no_err", err_n[0], 0);
      chk("t6_no_trip", wdog_trip, 1'b0);
      chk("t6_stb_held", s_stb, 1'b1);
      m0_cyc = 0; m0_stb = 0;
      ack_en = 1;
      tick(); tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
